sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO; next generation of the team's FIFO buffer family. Adds configurable width and depth, a fill-level count, programmable almost-full and almost-empty thresholds, and sticky overflow/underflow error flags. Used wherever producer and consumer share one clock domain, and drives the same write/read handshake our FIFO testbench interface already monitors.

## Interface
- DATA_WIDTH, 12, width of wData/rData
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (16 by default)
- AF_LEVEL, 12, almostFull asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almostEmpty asserts when count <= AE_LEVEL
- Legal range: 0 <= AE_LEVEL < AF_LEVEL <= DEPTH; elaboration-time error otherwise

- clk  input  1  single clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- wData  input  DATA_WIDTH  write data
- winc  input  1  write request
- rinc  input  1  read request
- clrErr  input  1  synchronous clear of overflow/underflow
- rData  output  DATA_WIDTH  registered read data
- wFull  output  1  FIFO holds DEPTH entries
- rEmpty  output  1  FIFO holds 0 entries
- almostFull  output  1  count >= AF_LEVEL
- almostEmpty  output  1  count <= AE_LEVEL
- count  output  ADDR_WIDTH+1  current fill level, 0..DEPTH
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Reset (rst low, immediate, independent of clk): pointers 0, count 0, rData 0, rEmpty 1, wFull 0, almostEmpty 1, almostFull 0, overflow 0, underflow 0. Memory contents not reset.
- Write accepted on an edge when winc=1 and wFull=0 (pre-edge value): mem[wptr] <= wData, wptr++.
- Read accepted on an edge when rinc=1 and rEmpty=0: rData <= mem[rptr], rptr++. rData holds its value when no read is accepted.
- Pointers are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address memory, MSB is the wrap bit. Wrap from DEPTH-1 to 0 is natural binary rollover.
- count update per edge: +1 write only, -1 read only, unchanged for both or neither.
- Flags are decodes of registered count/pointers only; no combinational path from winc/rinc/wData to any output.
- Simultaneous winc+rinc:
  - neither flag set: both accepted, count unchanged.
  - full: read accepted, write rejected, count DEPTH-1, overflow set.
  - empty: write accepted, read rejected, count 1, underflow set. No fall-through: written word readable next cycle at earliest.
- overflow sets on any edge with winc=1 and wFull=1; underflow on rinc=1 and rEmpty=1. Rejected accesses change no pointer, count, memory or rData.
- clrErr=1 clears both sticky flags on that edge; if a new error occurs on the same edge, set wins.

## Timing
- Write-to-read latency: word written on edge N visible as rEmpty=0 after edge N; readable by rinc on edge N+1; on rData after edge N+1.
- Read latency: rData valid one cycle after the accepting edge (registered output).
- All flags and count reflect state after each edge; single-cycle update, no lag.
- Reset assertion mid-operation discards all contents within the same cycle; first legal access on the first edge after rst deasserts.
- Throughput: one write and one read per cycle sustained.

## Test plan
- Reset: hold rst low, toggle winc/rinc -> count 0, rEmpty 1, wFull 0, almostEmpty 1, rData 0; release, write 0xABC, read -> rData 0xABC one cycle after rinc edge.
- Fill/drain (defaults): write 0x000..0x00F -> almostEmpty drops when count=3, almostFull rises at count=12, wFull at 16; read 16 -> data 0x000..0x00F in order, rEmpty at 0.
- Overflow: at count 16 assert winc with 0xFFF -> overflow=1, count stays 16, next 16 reads contain no 0xFFF; clrErr pulse -> overflow 0.
- Underflow + simultaneous on empty: empty, winc+rinc with 0x123 -> underflow 1, count 1, rData unchanged; next read returns 0x123.
- Wrap and concurrent traffic: 40 cycles of winc+rinc at count 5 with incrementing data -> count constant 5, output order matches input across pointer wrap.
- Full + simultaneous, then clrErr race: at count 16 winc+rinc -> count 15, overflow 1; clrErr with another overflow on same edge -> overflow stays 1.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count, programmable almost-full/empty thresholds
// and sticky overflow/underflow flags. Read data is registered (no fall-through).
module sync_fifo #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wData,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic                  clrErr,
  output logic [DATA_WIDTH-1:0] rData,
  output logic                  wFull,
  output logic                  rEmpty,
  output logic                  almostFull,
  output logic                  almostEmpty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  if (AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_bad_levels
    $error("sync_fifo: require 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH:0]   rptr_q, rptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty, wr_ok, rd_ok;

  // Status decodes come only from registered count, never from the request inputs.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign wr_ok = winc && !full;
  assign rd_ok = rinc && !empty;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    rdata_d     = rdata_q;
    overflow_d  = (overflow_q  && !clrErr) || (winc && full);
    underflow_d = (underflow_q && !clrErr) || (rinc && empty);

    if (wr_ok) wptr_d = wptr_q + ONE_C;
    if (rd_ok) begin
      rptr_d  = rptr_q + ONE_C;
      rdata_d = mem_q[rptr_q[ADDR_WIDTH-1:0]];
    end

    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      rdata_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      rdata_q     <= rdata_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wptr_q[ADDR_WIDTH-1:0]] <= wData;
  end

  assign rData       = rdata_q;
  assign wFull       = full;
  assign rEmpty      = empty;
  assign almostFull  = (count_q >= AF_C);
  assign almostEmpty = (count_q <= AE_C);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed + short random stimulus for sync_fifo against a queue scoreboard
// with an independent flag/count model.
module tb_sync_fifo;

  localparam int DW = 12;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] wData = '0;
  logic          winc = 1'b0;
  logic          rinc = 1'b0;
  logic          clrErr = 1'b0;
  logic [DW-1:0] rData;
  logic          wFull, rEmpty, almostFull, almostEmpty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wData      (wData),
    .winc       (winc),
    .rinc       (rinc),
    .clrErr     (clrErr),
    .rData      (rData),
    .wFull      (wFull),
    .rEmpty     (rEmpty),
    .almostFull (almostFull),
    .almostEmpty(almostEmpty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_rdata = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_udf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n;
    n = sb.size();
    check("count",       32'(count),       32'(n));
    check("rEmpty",      32'(rEmpty),      32'(n == 0));
    check("wFull",       32'(wFull),       32'(n == DEPTH));
    check("almostFull",  32'(almostFull),  32'(n >= AF));
    check("almostEmpty", 32'(almostEmpty), 32'(n <= AE));
    check("rData",       32'(rData),       32'(exp_rdata));
    check("overflow",    32'(overflow),    32'(exp_ovf));
    check("underflow",   32'(underflow),   32'(exp_udf));
  endtask

  // One clock: drive after the falling edge, model at the rising edge, check 1 time unit later.
  task automatic cycle(input logic w, input logic r, input logic [DW-1:0] d, input logic clr);
    bit full, empty;
    @(negedge clk);
    winc = w; rinc = r; wData = d; clrErr = clr;
    @(posedge clk);
    full  = (sb.size() == DEPTH);
    empty = (sb.size() == 0);
    if (r && !empty) exp_rdata = sb.pop_front();
    if (w && !full) sb.push_back(d);
    exp_ovf = (exp_ovf && !clr) || (w && full);
    exp_udf = (exp_udf && !clr) || (r && empty);
    #1;
    check_all();
  endtask

  initial begin
    // Reset held: requests must be ignored.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      winc = i[0]; rinc = ~i[0]; wData = 12'h5A5;
      @(posedge clk); #1;
      check_all();
    end
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0;
    rst = 1'b1;

    cycle(1'b1, 1'b0, 12'hABC, 1'b0);
    cycle(1'b0, 1'b1, 12'h000, 1'b0);
    check("first_read", 32'(rData), 32'h0ABC);

    // Fill, overflow attempt, clear, drain.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
    cycle(1'b1, 1'b0, 12'hFFF, 1'b0);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, 12'h000, 1'b0);
      check("drain_order", 32'(rData), 32'(i));
    end

    // Simultaneous access on empty: write lands, read rejected.
    cycle(1'b1, 1'b1, 12'h123, 1'b0);
    cycle(1'b0, 1'b1, 12'h000, 1'b1);
    check("after_underflow", 32'(rData), 32'h0123);

    // Steady concurrent traffic across pointer wrap.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(12'h200 + i), 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b1, DW'(12'h300 + i), 1'b0);
    while (sb.size() != 0) cycle(1'b0, 1'b1, 12'h000, 1'b0);

    // Full + simultaneous, then clear racing a fresh overflow.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(12'h400 + i), 1'b0);
    cycle(1'b1, 1'b1, 12'h7EE, 1'b0);
    cycle(1'b1, 1'b0, 12'h7EF, 1'b0);
    cycle(1'b1, 1'b0, 12'h7F0, 1'b1);
    cycle(1'b0, 1'b0, 12'h000, 1'b1);

    // Random mix.
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 7) == 0));

    // Asynchronous reset mid-operation.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DW'(12'h600 + i), 1'b0);
    cycle(1'b0, 1'b1, 12'h000, 1'b0);
    @(negedge clk);
    winc = 1'b0; rinc = 1'b0; clrErr = 1'b0;
    #2 rst = 1'b0;
    #1;
    sb.delete();
    exp_rdata = '0; exp_ovf = 1'b0; exp_udf = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b1, 1'b0, 12'h777, 1'b0);
    cycle(1'b0, 1'b1, 12'h000, 1'b0);
    check("post_reset_read", 32'(rData), 32'h0777);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
